usec_timer: RTL
===============

USEC_TIMER -- requirements
Module: usec_timer

Interface
REQ-001 SHALL have parameter CLKSPDMHZ, default 100, clk cycles per microsecond tick (>=1).
REQ-002 SHALL have parameter WIDTH, default 32, width of length, count and capture values.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  high: timer advances and start is accepted; low: everything holds.
REQ-006 SHALL have port start  input  1  single-cycle request that latches mode and micros_len and begins timing.
REQ-007 SHALL have port abort  input  1  return to IDLE without done.
REQ-008 SHALL have port mode  input  2  00 one-shot, 01 periodic, 10 measure, 11 reserved (treated as one-shot).
REQ-009 SHALL have port micros_len  input  WIDTH  period or timeout length in microseconds.
REQ-010 SHALL have port gate  input  1  echo pulse for measure mode, already synchronised to clk.
REQ-011 SHALL have port done  output  1  one-cycle pulse when a period, measurement or timeout completes.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port count  output  WIDTH  elapsed microseconds in the current period or window.
REQ-014 SHALL have port capture  output  WIDTH  last measured gate-high width in microseconds.
REQ-015 SHALL have port capture_valid  output  1  one-cycle pulse when capture updates with a real measurement.
REQ-016 SHALL have port timeout  output  1  one-cycle pulse when measure mode reaches micros_len.

Function
REQ-017 SHALL use states IDLE, RUN (one-shot/periodic), ARM (measure, waiting for gate rise) and MEAS (measure, gate high).
REQ-018 SHALL clear the prescaler on start and on ARM->MEAS, produce a tick every CLKSPDMHZ enabled cycles outside IDLE, and increment count by 1 on each tick.
REQ-019 When enable is low, the prescaler, count, state and gate history SHALL hold, start SHALL be ignored, and done, capture_valid and timeout SHALL be 0.
REQ-020 On an accepted start, in any state, the block SHALL latch mode and micros_len, clear count and the prescaler, and enter RUN (mode 00/01/11) or ARM (mode 10).
REQ-021 abort SHALL take priority over start, force IDLE, keep count, and raise no pulses; it SHALL act while enable is low.
REQ-022 One-shot: on the tick that makes count equal to the latched length, done SHALL pulse, state SHALL go to IDLE and count SHALL hold at that length.
REQ-023 Periodic: on that same tick, done SHALL pulse, count SHALL return to 0 and the block SHALL stay in RUN; the period is length*CLKSPDMHZ cycles with no slip.
REQ-024 A latched length of 0 SHALL pulse done, and timeout in measure mode, one cycle after start and return to IDLE, for all modes.
REQ-025 Measure: the gate rising edge (gate high, previous sample low) in ARM SHALL clear count and the prescaler and enter MEAS.
REQ-026 Measure: the gate falling edge in MEAS SHALL load capture with count and pulse capture_valid and done, then enter IDLE.
REQ-027 Measure: reaching count == length in ARM or MEAS SHALL pulse timeout and done, set capture to all-ones, not pulse capture_valid, and enter IDLE.
REQ-028 If a gate fall and the length-reaching tick occur in the same cycle, the gate fall SHALL win: capture = length, capture_valid pulses, and timeout stays 0.
REQ-029 A gate level that is already high at start SHALL NOT count as a rising edge; the gate history SHALL be sampled on the start cycle.
REQ-030 The count arithmetic SHALL be WIDTH bits; count never exceeds the latched length, so no wrap-around occurs.

Reset
REQ-031 While reset is low, the block SHALL asynchronously force IDLE, prescaler 0, count 0, capture 0, gate history 0, and done, busy, capture_valid and timeout to 0.
REQ-032 Reset deassertion SHALL take effect at the next clk edge; a start in that cycle SHALL be accepted.
REQ-033 Reset asserted mid-operation SHALL discard the operation with no done pulse.

Verification (CLKSPDMHZ=4, WIDTH=16)
REQ-034 One-shot, micros_len=3, start at cycle 0 -> done high exactly at cycle 12, busy low from cycle 13, count=3 held.
REQ-035 Periodic, micros_len=2 for 3 periods -> done at cycles 8, 16 and 24; enable low for 5 cycles inside the second period delays later pulses by 5.
REQ-036 Measure, micros_len=100, gate rises at 20 and falls at 60 -> capture=10, capture_valid and done pulse together, timeout=0.
REQ-037 Measure, micros_len=5, gate never rises -> timeout and done at cycle 20, capture=0xFFFF, capture_valid=0; repeat with gate falling on the length-reaching tick -> capture=5, capture_valid=1, timeout=0.
REQ-038 micros_len=0 in each mode -> done one cycle after start; abort and start together -> IDLE, no pulse; reset pulsed mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/usec_timer.sv
// Microsecond timer with one-shot, periodic and gate-width measure modes, driven by a CLKSPDMHZ-cycle prescaler.
// done/capture_valid/timeout pulse combinationally in the completing cycle; busy/count/capture are registered.
module usec_timer #(
  parameter int CLKSPDMHZ = 100,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] micros_len,
  input  logic             gate,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] capture,
  output logic             capture_valid,
  output logic             timeout
);
  localparam int            PW        = (CLKSPDMHZ > 1) ? $clog2(CLKSPDMHZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKSPDMHZ - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ARM, S_MEAS} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_presc, w_presc_nxt, w_presc_adv;
  logic [WIDTH-1:0] r_count, w_count_nxt, w_count_adv;
  logic [WIDTH-1:0] r_len, w_len_nxt;
  logic [WIDTH-1:0] r_capture, w_capture_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             r_gate_prev;
  logic             w_tick, w_zero, w_reach, w_rise, w_fall;
  logic             w_done, w_cv, w_to;

  assign w_tick      = enable && (r_state != S_IDLE) && (r_presc == PRESC_MAX);
  assign w_presc_adv = w_tick ? '0 : r_presc + 1'b1;
  assign w_count_adv = w_tick ? r_count + 1'b1 : r_count;
  assign w_zero      = (r_len == '0);
  // A zero length completes on the first cycle after start, without waiting for a tick.
  assign w_reach     = w_zero || (w_tick && (w_count_adv == r_len));
  assign w_rise      = gate && !r_gate_prev;
  assign w_fall      = !gate && r_gate_prev;

  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_count_nxt   = r_count;
    w_len_nxt     = r_len;
    w_mode_nxt    = r_mode;
    w_capture_nxt = r_capture;
    w_done        = 1'b0;
    w_cv          = 1'b0;
    w_to          = 1'b0;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else if (enable) begin
      if (start) begin
        w_mode_nxt  = mode;
        w_len_nxt   = micros_len;
        w_count_nxt = '0;
        w_presc_nxt = '0;
        w_state_nxt = (mode == 2'b10) ? S_ARM : S_RUN;
      end else begin
        case (r_state)
          S_RUN: begin
            w_presc_nxt = w_presc_adv;
            w_count_nxt = w_count_adv;
            if (w_reach) begin
              w_done = 1'b1;
              if (w_zero) begin
                w_count_nxt = r_count;
                w_state_nxt = S_IDLE;
              end else if (r_mode == 2'b01) begin
                w_count_nxt = '0;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          end
          S_ARM, S_MEAS: begin
            w_presc_nxt = w_presc_adv;
            w_count_nxt = w_count_adv;
            // Gate fall beats the length-reaching tick so a full-length echo still reports its width.
            if ((r_state == S_MEAS) && w_fall) begin
              w_capture_nxt = w_count_adv;
              w_cv          = 1'b1;
              w_done        = 1'b1;
              w_state_nxt   = S_IDLE;
            end else if (w_reach) begin
              w_to          = 1'b1;
              w_done        = 1'b1;
              w_capture_nxt = '1;
              w_state_nxt   = S_IDLE;
              if (w_zero) w_count_nxt = r_count;
            end else if ((r_state == S_ARM) && w_rise) begin
              w_count_nxt = '0;
              w_presc_nxt = '0;
              w_state_nxt = S_MEAS;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_mode      <= 2'b00;
      r_capture   <= '0;
      r_gate_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_count   <= w_count_nxt;
      r_len     <= w_len_nxt;
      r_mode    <= w_mode_nxt;
      r_capture <= w_capture_nxt;
      if (enable) r_gate_prev <= gate;
    end
  end

  assign done          = w_done;
  assign busy          = (r_state != S_IDLE);
  assign count         = r_count;
  assign capture       = r_capture;
  assign capture_valid = w_cv;
  assign timeout       = w_to;

endmodule
